mc_control_fsm: RTL and testbench

- Multicycle main controller for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback over shared ALU, memory port and register file.
- Drives ImmSrc to the decode-stage sign extender plus all datapath mux selects and write enables.
- Sits beside the ALU decoder and issues alu_op only; it waits on a ready/request memory handshake.

---
 rtl/ctrl_pkg.sv | 81 ++++++++
 rtl/mc_output_decode.sv | 118 +++++++++++
 rtl/mc_control_fsm.sv | 110 +++++++++++
 tb/tb_mc_control_fsm.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I main controller.
// Holds the immediate-type enum, the controller state enum, opcode
// constants, datapath select encodings and the bundled control word.
package ctrl_pkg;

  localparam int unsigned OP_W = 7;

  typedef enum logic [2:0] {
    IMM    = 3'b000,
    STORE  = 3'b001,
    BRANCH = 3'b010,
    UPPER  = 3'b011,
    JUMP   = 3'b100
  } sign_extention_type;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JALR     = 4'd11,
    ST_LUI      = 4'd12,
    ST_AUIPC    = 4'd13,
    ST_TRAP     = 4'd14
  } state_t;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // alu_src_a
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // alu_src_b
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // alu_op
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // result_src
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic               mem_req;
    logic               mem_write;
    logic               adr_src;
    logic               ir_write;
    logic               pc_write;
    logic               reg_write;
    sign_extention_type imm_src;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         result_src;
    logic               trap;
  } ctrl_out_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decode for the multicycle controller.
// Ports:
//   state     - current controller state
//   op        - instr[6:0]
//   funct3    - instr[14:12] (unused here beyond branch sense)
//   zero      - ALU zero flag, qualifies pc_write in BRANCH
//   mem_ready - memory handshake, qualifies ir_write/pc_write in FETCH
//   ctrl      - full control word for the datapath
module mc_output_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W = ctrl_pkg::OP_W
) (
  input  state_t          state,
  input  logic [OP_W-1:0] op,
  input  logic [2:0]      funct3,
  input  logic            zero,
  input  logic            mem_ready,
  output ctrl_out_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b0;
        // PC+4 is only committed in the cycle the fetch completes
        if (mem_ready) begin
          ctrl.ir_write   = 1'b1;
          ctrl.pc_write   = 1'b1;
          ctrl.alu_src_a  = SRCA_PC;
          ctrl.alu_src_b  = SRCB_FOUR;
          ctrl.result_src = RES_ALU;
        end
      end
      ST_DECODE: begin
        // Speculative target into ALUOut
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.imm_src   = (op == OPC_JAL) ? JUMP : BRANCH;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.imm_src   = (op == OPC_STORE) ? STORE : IMM;
      end
      ST_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.result_src = RES_MEM;
        ctrl.reg_write  = 1'b1;
      end
      ST_MEMWRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.adr_src   = 1'b1;
      end
      ST_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        // funct3[0] inverts the sense: beq takes on zero, bne on non-zero
        ctrl.pc_write   = zero ^ funct3[0];
      end
      ST_JALR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
      end
      ST_LUI: begin
        ctrl.alu_src_a = SRCA_ZERO;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = UPPER;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_AUIPC: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = UPPER;
        ctrl.alu_op    = ALUOP_ADD;
      end
      default: begin
        // ST_TRAP and any unreachable encoding
        ctrl.trap = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle main controller for the RV32I core. Sequences fetch, decode,
// execute, memory and writeback; issues alu_op for the separate ALU decoder.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   op, funct3        - instruction fields from the instruction register
//   zero              - ALU zero flag
//   mem_ready         - memory completes the outstanding request this cycle
//   mem_req/mem_write - memory request and store qualifier
//   adr_src           - memory address select (PC / ALUOut)
//   ir_write/pc_write/reg_write - datapath write enables
//   ImmSrc            - sign extender immediate type
//   alu_src_a/alu_src_b/alu_op/result_src - datapath selects
//   trap              - sticky illegal-instruction flag
module mc_control_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W = ctrl_pkg::OP_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic [2:0]      funct3,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_write,
  output logic            adr_src,
  output logic            ir_write,
  output logic            pc_write,
  output logic            reg_write,
  output logic [2:0]      ImmSrc,
  output logic [1:0]      alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      result_src,
  output logic            trap
);

  state_t    state;
  state_t    state_next;
  ctrl_out_t ctrl;
  ctrl_out_t ctrl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:    if (mem_ready) state_next = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OPC_LOAD, OPC_STORE: state_next = ST_MEMADR;
          OPC_RTYPE:           state_next = ST_EXECR;
          OPC_ITYPE:           state_next = ST_EXECI;
          OPC_BRANCH:          state_next = (funct3[2:1] == 2'b00) ? ST_BRANCH : ST_TRAP;
          OPC_JAL:             state_next = ST_JAL;
          OPC_JALR:            state_next = ST_JALR;
          OPC_LUI:             state_next = ST_LUI;
          OPC_AUIPC:           state_next = ST_AUIPC;
          default:             state_next = ST_TRAP;
        endcase
      end
      ST_MEMADR:   state_next = (op == OPC_STORE) ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  if (mem_ready) state_next = ST_MEMWB;
      ST_MEMWB:    state_next = ST_FETCH;
      ST_MEMWRITE: if (mem_ready) state_next = ST_FETCH;
      ST_EXECR:    state_next = ST_ALUWB;
      ST_EXECI:    state_next = ST_ALUWB;
      ST_ALUWB:    state_next = ST_FETCH;
      ST_BRANCH:   state_next = ST_FETCH;
      ST_JALR:     state_next = ST_JAL;
      ST_JAL:      state_next = ST_ALUWB;
      ST_LUI:      state_next = ST_ALUWB;
      ST_AUIPC:    state_next = ST_ALUWB;
      default:     state_next = ST_TRAP;
    endcase
  end

  mc_output_decode #(.OP_W(OP_W)) u_output_decode (
    .state     (state),
    .op        (op),
    .funct3    (funct3),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Reset masks the control word combinationally so an in-flight store or
  // fetch handshake drops in the same cycle rst_n falls.
  always_comb begin
    ctrl_q = rst_n ? ctrl : '0;
  end

  assign mem_req    = ctrl_q.mem_req;
  assign mem_write  = ctrl_q.mem_write;
  assign adr_src    = ctrl_q.adr_src;
  assign ir_write   = ctrl_q.ir_write;
  assign pc_write   = ctrl_q.pc_write;
  assign reg_write  = ctrl_q.reg_write;
  assign ImmSrc     = ctrl_q.imm_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign result_src = ctrl_q.result_src;
  assign trap       = ctrl_q.trap;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed-vector bench for mc_control_fsm. Each vector is the full output
// word {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, ImmSrc,
// alu_src_a, alu_src_b, alu_op, result_src, trap} sampled at the falling edge.
module tb_mc_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [2:0] ImmSrc;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       trap;

  int unsigned vectors;
  int unsigned miscompares;

  mc_control_fsm #(.OP_W(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .ImmSrc     (ImmSrc),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .trap       (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] ev(
    input logic mreq, input logic mwr, input logic adr, input logic irw,
    input logic pcw, input logic rw, input logic [2:0] imm,
    input logic [1:0] a, input logic [1:0] b, input logic [1:0] aop,
    input logic [1:0] rs, input logic tr);
    return {mreq, mwr, adr, irw, pcw, rw, imm, a, b, aop, rs, tr};
  endfunction

  function automatic logic [17:0] obs();
    return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
            ImmSrc, alu_src_a, alu_src_b, alu_op, result_src, trap};
  endfunction

  task automatic check_vec(input string tag, input logic [17:0] got, input logic [17:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Sample at the falling edge, then advance to just past the next rising edge.
  task automatic cyc(input string tag, input logic [17:0] exp);
    @(negedge clk);
    check_vec(tag, obs(), exp);
    @(posedge clk);
    #1;
  endtask

  // Expected words, hand-derived from the state table.
  logic [17:0] F_RDY, F_WAIT, DEC_BR, DEC_J, MA_LD, MA_ST, MRD, MWB, MWR;
  logic [17:0] EXR, EXI, AWB, BR_T, BR_N, JALR_V, JAL_V, LUI_V, AUIPC_V, TRAP_V, ZERO_V;

  initial begin
    F_RDY   = ev(1,0,0,1,1,0,3'b000,2'b00,2'b10,2'b00,2'b10,0);
    F_WAIT  = ev(1,0,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,0);
    DEC_BR  = ev(0,0,0,0,0,0,3'b010,2'b01,2'b01,2'b00,2'b00,0);
    DEC_J   = ev(0,0,0,0,0,0,3'b100,2'b01,2'b01,2'b00,2'b00,0);
    MA_LD   = ev(0,0,0,0,0,0,3'b000,2'b10,2'b01,2'b00,2'b00,0);
    MA_ST   = ev(0,0,0,0,0,0,3'b001,2'b10,2'b01,2'b00,2'b00,0);
    MRD     = ev(1,0,1,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,0);
    MWB     = ev(0,0,0,0,0,1,3'b000,2'b00,2'b00,2'b00,2'b01,0);
    MWR     = ev(1,1,1,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,0);
    EXR     = ev(0,0,0,0,0,0,3'b000,2'b10,2'b00,2'b10,2'b00,0);
    EXI     = ev(0,0,0,0,0,0,3'b000,2'b10,2'b01,2'b10,2'b00,0);
    AWB     = ev(0,0,0,0,0,1,3'b000,2'b00,2'b00,2'b00,2'b00,0);
    BR_T    = ev(0,0,0,0,1,0,3'b000,2'b10,2'b00,2'b01,2'b00,0);
    BR_N    = ev(0,0,0,0,0,0,3'b000,2'b10,2'b00,2'b01,2'b00,0);
    JALR_V  = ev(0,0,0,0,0,0,3'b000,2'b10,2'b01,2'b00,2'b00,0);
    JAL_V   = ev(0,0,0,0,1,0,3'b000,2'b01,2'b10,2'b00,2'b00,0);
    LUI_V   = ev(0,0,0,0,0,0,3'b011,2'b11,2'b01,2'b00,2'b00,0);
    AUIPC_V = ev(0,0,0,0,0,0,3'b011,2'b01,2'b01,2'b00,2'b00,0);
    TRAP_V  = ev(0,0,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,1);
    ZERO_V  = '0;

    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b010; zero = 1'b0; mem_ready = 1'b1;

    // Reset holds outputs at zero even with mem_ready high in FETCH
    #12;
    check_vec("reset", obs(), ZERO_V);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // lw, memory always ready
    cyc("lw fetch", F_RDY);
    cyc("lw decode", DEC_BR);
    cyc("lw memadr", MA_LD);
    cyc("lw memread", MRD);
    cyc("lw memwb", MWB);

    // sw, three wait cycles in MEMWRITE
    op = 7'b0100011;
    cyc("sw fetch", F_RDY);
    cyc("sw decode", DEC_BR);
    cyc("sw memadr", MA_ST);
    mem_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) cyc("sw memwrite wait", MWR);
    mem_ready = 1'b1;
    cyc("sw memwrite done", MWR);

    // Fetch stall, then beq taken
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b1; mem_ready = 1'b0;
    cyc("fetch stall 1", F_WAIT);
    cyc("fetch stall 2", F_WAIT);
    mem_ready = 1'b1;
    cyc("beq fetch", F_RDY);
    cyc("beq decode", DEC_BR);
    cyc("beq taken", BR_T);

    // bne with zero=1 not taken; bne with zero=0 taken
    funct3 = 3'b001;
    cyc("bne fetch", F_RDY);
    cyc("bne decode", DEC_BR);
    cyc("bne zero1", BR_N);
    zero = 1'b0;
    cyc("bne2 fetch", F_RDY);
    cyc("bne2 decode", DEC_BR);
    cyc("bne zero0", BR_T);

    // R-type and I-type through ALUWB
    op = 7'b0110011;
    cyc("rtype fetch", F_RDY);
    cyc("rtype decode", DEC_BR);
    cyc("rtype exec", EXR);
    cyc("rtype wb", AWB);
    op = 7'b0010011;
    cyc("itype fetch", F_RDY);
    cyc("itype decode", DEC_BR);
    cyc("itype exec", EXI);
    cyc("itype wb", AWB);

    // jal, jalr
    op = 7'b1101111;
    cyc("jal fetch", F_RDY);
    cyc("jal decode", DEC_J);
    cyc("jal jal", JAL_V);
    cyc("jal wb", AWB);
    op = 7'b1100111;
    cyc("jalr fetch", F_RDY);
    cyc("jalr decode", DEC_BR);
    cyc("jalr jalr", JALR_V);
    cyc("jalr jal", JAL_V);
    cyc("jalr wb", AWB);

    // lui, auipc
    op = 7'b0110111;
    cyc("lui fetch", F_RDY);
    cyc("lui decode", DEC_BR);
    cyc("lui exec", LUI_V);
    cyc("lui wb", AWB);
    op = 7'b0010111;
    cyc("auipc fetch", F_RDY);
    cyc("auipc decode", DEC_BR);
    cyc("auipc exec", AUIPC_V);
    cyc("auipc wb", AWB);

    // Branch with illegal funct3 traps; reset is the only exit
    op = 7'b1100011; funct3 = 3'b100;
    cyc("bad branch fetch", F_RDY);
    cyc("bad branch decode", DEC_BR);
    cyc("bad branch trap", TRAP_V);
    cyc("bad branch trap held", TRAP_V);
    rst_n = 1'b0; #2; rst_n = 1'b1;

    // Illegal opcode: trap held 20 cycles, mem_ready ignored
    op = 7'b1111111;
    cyc("illegal fetch", F_RDY);
    cyc("illegal decode", DEC_BR);
    for (int unsigned i = 0; i < 20; i++) cyc("illegal trap held", TRAP_V);
    rst_n = 1'b0; #2; rst_n = 1'b1;

    // Reset asserted mid-MEMWRITE drops mem_write at once
    op = 7'b0100011; funct3 = 3'b010;
    cyc("sw2 fetch", F_RDY);
    cyc("sw2 decode", DEC_BR);
    cyc("sw2 memadr", MA_ST);
    mem_ready = 1'b0;
    @(negedge clk);
    check_vec("sw2 memwrite", obs(), MWR);
    #1 rst_n = 1'b0;
    #1 check_vec("sw2 reset mid-store", obs(), ZERO_V);
    @(posedge clk); #1;
    check_vec("sw2 reset held", obs(), ZERO_V);
    rst_n = 1'b1;
    cyc("after reset fetch", F_WAIT);
    cyc("after reset fetch hold", F_WAIT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
